// File: rtl/debounce_scanner_pkg.sv
// Shared types and helpers for the time-multiplexed debounce scanner.
package debounce_scanner_pkg;

  // Scan controller states: waiting for a tick, or walking the channels.
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Ceiling log2 usable in constant expressions (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Channel index width; a single input still gets a 1-bit channel field.
  function automatic int chan_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_scanner_event_fifo.sv
// Small synchronous FIFO for debounce edge events. A push into a full
// queue is still accepted when the head is popped in the same cycle.
module event_fifo
  import debounce_scanner_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/debounce_scanner.sv
// Debounce controller: one shared glitch-filter datapath visits every noisy
// input once per scan tick and queues committed level changes as events.
module debounce_scanner
  import debounce_scanner_pkg::*;
#(
  parameter int N_INPUTS      = 8,
  parameter int FILTER_CYCLES = 5,
  parameter int SCAN_DIV      = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_INPUTS-1:0]               in,
  input  logic                              enable,
  output logic [N_INPUTS-1:0]               level,
  output logic                              evt_valid,
  input  logic                              evt_ready,
  output logic [chan_width(N_INPUTS)-1:0]   evt_chan,
  output logic                              evt_rise,
  output logic                              overflow,
  input  logic                              clr_overflow
);

  localparam int CW = chan_width(N_INPUTS);
  localparam int PW = clog2(SCAN_DIV);

  if (SCAN_DIV < N_INPUTS + 2) begin : g_scan_div_check
    $error("SCAN_DIV must be at least N_INPUTS+2");
  end

  logic [N_INPUTS-1:0]      sync1;
  logic [N_INPUTS-1:0]      in_s;
  logic [PW-1:0]            pre_cnt;
  logic                     tick;
  scan_state_t              state;
  logic [CW-1:0]            ch;
  // Only the newest F-1 samples are kept: the oldest one falls out of the
  // window on the very shift that evaluates it, so it is never needed again.
  logic [FILTER_CYCLES-2:0] hist [N_INPUTS];
  logic [N_INPUTS-1:0]      level_q;
  logic [FILTER_CYCLES-1:0] window;
  logic                     scanning;
  logic                     rise_evt;
  logic                     fall_evt;
  logic                     push_evt;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     pop_now;
  logic                     drop;
  logic [CW:0]              fifo_head;

  // Two-flop synchronizer on every raw input before the sampler sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      in_s  <= '0;
    end else begin
      sync1 <= in;
      in_s  <= sync1;
    end
  end

  assign tick = enable && (pre_cnt == PW'(SCAN_DIV - 1));

  // Scan prescaler: free-runs while enabled, parked at zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pre_cnt <= '0;
    else if (!enable) pre_cnt <= '0;
    else if (tick)    pre_cnt <= '0;
    else              pre_cnt <= pre_cnt + 1'b1;
  end

  // Shared evaluation datapath for the channel currently selected by ch.
  assign window   = {hist[ch], in_s[ch]};
  assign scanning = (state == SCAN);
  assign rise_evt = scanning && (&window) && !level_q[ch];
  assign fall_evt = scanning && !(|window) && level_q[ch];
  assign push_evt = rise_evt || fall_evt;

  // Scan FSM with history and debounced level updates for the visited channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ch      <= '0;
      level_q <= '0;
      for (int i = 0; i < N_INPUTS; i++) hist[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            state <= SCAN;
            ch    <= '0;
          end
        end
        SCAN: begin
          hist[ch] <= window[FILTER_CYCLES-2:0];
          if (rise_evt) level_q[ch] <= 1'b1;
          if (fall_evt) level_q[ch] <= 1'b0;
          if (ch == CW'(N_INPUTS - 1)) begin
            state <= IDLE;
            ch    <= '0;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ch    <= '0;
        end
      endcase
    end
  end

  assign pop_now = evt_ready && !fifo_empty;
  assign drop    = push_evt && fifo_full && !pop_now;

  event_fifo #(
    .WIDTH (CW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_event_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_evt),
    .push_data ({ch, rise_evt}),
    .pop       (evt_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sticky overflow: a drop in the same cycle beats a clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  assign level     = level_q;
  assign evt_valid = !fifo_empty;
  assign evt_chan  = fifo_head[CW:1];
  assign evt_rise  = fifo_head[0];

endmodule

// File: tb/tb_debounce_scanner.sv
// Scoreboard bench for debounce_scanner: a run-length reference model
// predicts levels and events per scan period; a monitor drains the queue.
module tb_debounce_scanner;

  localparam int N     = 8;
  localparam int F     = 5;
  localparam int DIV   = 16;
  localparam int DEPTH = 4;

  localparam int MODE_RANDOM = 0;
  localparam int MODE_STALL  = 1;
  localparam int MODE_PULSE  = 2;
  localparam int MODE_READY  = 3;

  typedef struct packed {
    logic [2:0] chan;
    logic       rise;
  } evt_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] in_raw;
  logic         enable;
  logic [N-1:0] level;
  logic         evt_valid;
  logic         evt_ready;
  logic [2:0]   evt_chan;
  logic         evt_rise;
  logic         overflow;
  logic         clr_overflow;

  int   n_checks = 0;
  int   n_fail   = 0;
  evt_t exp_q[$];
  bit   m_level[N];
  bit   m_last[N];
  int   m_run[N];
  bit   m_ovf;
  bit   hold_valid;
  evt_t hold_head;

  debounce_scanner #(
    .N_INPUTS      (N),
    .FILTER_CYCLES (F),
    .SCAN_DIV      (DIV),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in           (in_raw),
    .enable       (enable),
    .level        (level),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_chan     (evt_chan),
    .evt_rise     (evt_rise),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  // Free-running bench clock.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      m_level[c] = 1'b0;
      m_last[c]  = 1'b0;
      m_run[c]   = F;
    end
    m_ovf = 1'b0;
    exp_q.delete();
  endfunction

  // One scan: each channel takes one sample; a level commits once the
  // same value has been seen F times in a row and differs from the level.
  function automatic void model_scan(input logic [N-1:0] sample, input int cap);
    evt_t e;
    for (int c = 0; c < N; c++) begin
      if (sample[c] == m_last[c]) begin
        if (m_run[c] < F) m_run[c]++;
      end else begin
        m_last[c] = sample[c];
        m_run[c]  = 1;
      end
      if (m_run[c] >= F && m_last[c] != m_level[c]) begin
        m_level[c] = m_last[c];
        e.chan = 3'(c);
        e.rise = m_last[c];
        if (exp_q.size() >= cap) m_ovf = 1'b1;
        else                     exp_q.push_back(e);
      end
    end
  endfunction

  function automatic logic [N-1:0] model_levels();
    logic [N-1:0] v;
    for (int c = 0; c < N; c++) v[c] = m_level[c];
    return v;
  endfunction

  // One scan period, entered just after the posedge 10 clocks past a tick
  // boundary, so the inputs stay stable across the whole sampling window.
  task automatic apply_stimulus(input logic [N-1:0] new_in, input int mode, input bit clr);
    int cap;
    check_output("level", level, model_levels());
    check_output("overflow", overflow, m_ovf);
    in_raw = new_in;
    if (clr) m_ovf = 1'b0;
    cap = (mode == MODE_STALL) ? DEPTH : (mode == MODE_PULSE) ? DEPTH + 1 : 1000;
    model_scan(new_in, cap);
    for (int j = 0; j < DIV; j++) begin
      clr_overflow = clr && (j == 0);
      case (mode)
        MODE_RANDOM: evt_ready = (j <= 10) ? 1'($urandom_range(1, 0)) : 1'b1;
        MODE_STALL:  evt_ready = 1'b0;
        MODE_PULSE:  evt_ready = (j == 11);
        default:     evt_ready = 1'b1;
      endcase
      @(posedge clk);
      #1;
    end
    clr_overflow = 1'b0;
  endtask

  // Release reset and line up with the scan phase the periods expect.
  task automatic release_reset();
    model_reset();
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every handshake and checks head stability under stall.
  always @(negedge clk) begin
    evt_t e;
    if (!rst_n) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) begin
        check_output("held_valid", evt_valid, 1'b1);
        check_output("held_head", {evt_chan, evt_rise}, hold_head);
      end
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_event: got chan %0d rise %0b, expected none at %0t",
                   evt_chan, evt_rise, $time);
        end else begin
          e = exp_q.pop_front();
          check_output("event", {evt_chan, evt_rise}, e);
        end
      end
      hold_valid = evt_valid && !evt_ready;
      hold_head  = {evt_chan, evt_rise};
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected end before 1000000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    logic [N-1:0] cur;
    int           idx;
    rst_n        = 1'b0;
    enable       = 1'b1;
    evt_ready    = 1'b1;
    clr_overflow = 1'b0;
    in_raw       = '0;
    model_reset();

    $display("[TB] reset hold with random inputs");
    repeat (20) begin
      in_raw = N'($urandom);
      @(negedge clk);
      check_output("rst_level", level, '0);
      check_output("rst_valid", evt_valid, 1'b0);
      check_output("rst_overflow", overflow, 1'b0);
    end
    @(posedge clk);
    #1;
    in_raw = '0;
    release_reset();
    repeat (3) apply_stimulus('0, MODE_RANDOM, 1'b0);

    $display("[TB] clean rise and fall on channel 3");
    repeat (6) apply_stimulus(8'h08, MODE_RANDOM, 1'b0);
    repeat (6) apply_stimulus(8'h00, MODE_RANDOM, 1'b0);

    $display("[TB] glitch rejection on channel 2");
    apply_stimulus(8'h04, MODE_RANDOM, 1'b0);
    for (int i = 0; i < 20; i++) apply_stimulus((i % 2 == 0) ? 8'h00 : 8'h04, MODE_RANDOM, 1'b0);
    repeat (5) apply_stimulus(8'h00, MODE_RANDOM, 1'b0);

    $display("[TB] randomized inputs");
    cur = '0;
    repeat (40) begin
      repeat (3) begin
        if ($urandom_range(1, 0) == 1) begin
          idx = int'($urandom_range(N - 1, 0));
          cur[idx] = ~cur[idx];
        end
      end
      apply_stimulus(cur, MODE_RANDOM, 1'b0);
    end
    repeat (6) apply_stimulus(8'h00, MODE_READY, 1'b0);

    $display("[TB] overflow and full-queue pass-through");
    repeat (5) apply_stimulus(8'h1F, MODE_STALL, 1'b0);
    apply_stimulus(8'h3F, MODE_STALL, 1'b1);
    repeat (3) apply_stimulus(8'h3F, MODE_STALL, 1'b0);
    apply_stimulus(8'h3F, MODE_PULSE, 1'b0);
    repeat (2) apply_stimulus(8'h3F, MODE_READY, 1'b0);

    $display("[TB] reset in the middle of a scan");
    repeat (6) apply_stimulus(8'hFF, MODE_READY, 1'b0);
    check_output("pre_reset_level", level, 8'hFF);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("midscan_level", level, '0);
    check_output("midscan_valid", evt_valid, 1'b0);
    check_output("midscan_chan", evt_chan, '0);
    check_output("midscan_rise", evt_rise, 1'b0);
    check_output("midscan_overflow", overflow, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    release_reset();
    repeat (6) apply_stimulus(8'hFF, MODE_READY, 1'b0);
    repeat (6) apply_stimulus(8'h00, MODE_READY, 1'b0);

    check_output("final_level", level, model_levels());
    check_output("final_overflow", overflow, m_ovf);
    check_output("final_valid", evt_valid, 1'b0);
    check_output("final_pending", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_scanner.md
# debounce_scanner

Time-multiplexed debounce controller that shares one glitch-filter evaluation datapath across `N_INPUTS` noisy external inputs. A prescaled scan tick walks the channels round-robin, updates each channel's sample history, and commits a debounced level only after `FILTER_CYCLES` consecutive agreeing samples. Each committed level change is queued as an edge event with a valid/ready handshake. It sits between raw board IO (buttons, switches, strap lines) and the control logic that consumes debounced levels and press/release events.

## Interface

- `N_INPUTS`, 8, number of noisy inputs scanned (1..64)
- `FILTER_CYCLES`, 5, consecutive agreeing samples required to commit a level (2..16)
- `SCAN_DIV`, 16, clocks per scan tick; must be ≥ `N_INPUTS`+2 (elaboration check)
- `FIFO_DEPTH`, 4, event queue depth (power of two, ≥2)

Ports:

- `clk` in 1: sole clock; all state is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in` in `N_INPUTS`: raw asynchronous inputs.
- `enable` in 1: scan enable.
- `level` out `N_INPUTS`: debounced levels.
- `evt_valid` out 1: event queue non-empty.
- `evt_ready` in 1: consumer accepts the head event.
- `evt_chan` out CW: channel of the head event, where CW = max(1, clog2(`N_INPUTS`)).
- `evt_rise` out 1: head event is a rising edge (0 = falling).
- `overflow` out 1: sticky flag, set when an event was dropped.
- `clr_overflow` in 1: synchronous clear of `overflow`.

## Operation

- **Synchronizer:** `in` passes through 2-flop synchronizers before any use (`in_s`).
- **Prescaler:** counts 0..`SCAN_DIV`-1 while `enable`=1 and asserts `tick` on the wrap cycle. With `enable`=0 it holds at 0.
- **FSM states:** IDLE and SCAN.
  - IDLE→SCAN on `tick`, with ch=0.
  - In SCAN, one channel is processed per cycle; ch increments.
  - SCAN→IDLE after processing ch=`N_INPUTS`-1.
  - Dropping `enable` mid-scan does not abort; the scan completes.
- **Per-channel processing of channel c:**
  - Update the history: hist[c] ← {hist[c][F-2:0], in_s[c]}.
  - The commit test uses the *updated* history. All-ones with level[c]=0 sets level[c]=1 and pushes a rise event. All-zeros with level[c]=1 sets level[c]=0 and pushes a fall event. Otherwise there is no change.
- **Event FIFO:**
  - A push is accepted if the queue is not full, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and `overflow` is set. The `level` update still happens.
  - A pop occurs when `evt_valid` & `evt_ready`.
  - Events leave in push order, which is ascending channel order within one scan.
- **`overflow`:**
  - Sets on any drop.
  - Cleared by `clr_overflow` only when no drop occurs in that cycle; set wins.
- **`evt_chan` / `evt_rise`:** reflect the head entry and are don't-care while `evt_valid`=0.

## Timing

- **Reset values (immediate, asynchronous):**
  - `level`=0, all histories 0, FIFO empty.
  - `evt_valid`=0, `evt_chan`=0, `evt_rise`=0, `overflow`=0.
  - Prescaler 0, FSM IDLE, synchronizers 0.
  - Reset asserted mid-scan aborts the scan; after release, scanning restarts from ch=0 on the next tick.
- **Scan timing:** with `tick` in cycle T, channel k is processed at the end of cycle T+1+k. `level[k]` and the pushed event (when the FIFO was empty) are visible in cycle T+2+k.
- **Input to sample latency:** an `in` change is visible to the sampler 2 clocks later.
- **Minimum debounce latency:** `FILTER_CYCLES` ticks after the first agreeing sample. A glitch shorter than one scan period never commits a change.
- **Handshake:**
  - `evt_valid` never deasserts without a pop or a reset.
  - The head is stable while `evt_valid`=1 and `evt_ready`=0.
- **Prescaler wrap:** the prescaler wraps every `SCAN_DIV` cycles. By the parameter constraint, a tick never arrives while in SCAN.

## Structure

- Shared include `common/debounce_defs.vh`: `CLOG2` function/macro, event field widths, and the FSM state encodings (IDLE=0, SCAN=1).
- One natural sub-module: `event_fifo`, a parameterized synchronous FIFO with push/pop/full/empty, async active-low reset, and pass-through on simultaneous push and pop when full.
- Histories are a register array indexed by ch, with a single shared evaluation datapath.

## Test plan

All scenarios use `N_INPUTS`=8, `FILTER_CYCLES`=5, `SCAN_DIV`=16, `FIFO_DEPTH`=4 unless stated.

- **Reset:** hold `rst_n`=0 with random `in` → `level`=0, `evt_valid`=0 and `overflow`=0 throughout. After release, no events while `in`=0.
- **Clean rise and fall:**
  - Set `in[3]`=1 and hold → `level[3]`=1 after the 5th tick that samples it, and exactly one event (chan=3, rise=1).
  - Clear `in[3]` → one fall event after 5 more ticks.
- **Glitch rejection:**
  - Pulse `in[2]` high for 16 clocks, then low → `level[2]` stays 0 and no event.
  - Repeat with alternating samples for 20 ticks → no event.
- **Overflow:**
  - With `evt_ready`=0, raise `in[0..4]` together → 4 events queued, channels 0,1,2,3. Channel 4 is dropped, `overflow`=1, and `level[4]`=1.
  - Pulse `clr_overflow` → `overflow`=0.
- **Full with simultaneous pop:**
  - Fill the FIFO, then assert `evt_ready` for exactly the cycle a new push occurs → push accepted, `overflow` stays 0, and the order is preserved.
- **Reset mid-scan:**
  - Assert `rst_n`=0 in cycle T+4 of a scan with committed levels → all outputs clear immediately.
  - After release with `in` held at 1 → levels recommit after 5 ticks.
